// File: rtl/display_scan_if.sv
// Frame/control inputs and scan outputs of the 8-digit seven-segment scan controller.
interface display_scan_if;
    logic [31:0] digits_in;
    logic [7:0]  digit_en;
    logic        lz_en;
    logic [7:0]  blink_mask;
    logic [3:0]  num;
    logic [7:0]  an_sel;
    logic [2:0]  scan_idx;

    modport master (
        output digits_in, digit_en, lz_en, blink_mask,
        input  num, an_sel, scan_idx
    );

    modport slave (
        input  digits_in, digit_en, lz_en, blink_mask,
        output num, an_sel, scan_idx
    );
endinterface

// File: rtl/display_scan.sv
// Time-multiplexed 8-digit scan with frame-atomic latching, digit enable and leading-zero blanking.
// Blinking is built only when DISPLAY_SCAN_BLINK_EN is defined.
module display_scan #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic         clk,
    input  logic         rst_n,
    display_scan_if.slave bus
);
    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       an_q;
    logic [3:0]       num_q, num_d;
    logic [31:0]      shadow_q, shadow_d;
    logic             load_pending_q;
    logic             tick, frame_tick, phase_on;
    logic [7:0]       all_zero;

    assign tick       = (div_q == DIV_W'(SCAN_DIV - 1));
    assign frame_tick = tick && (idx_q == 3'd7);
    assign div_d      = tick ? '0 : div_q + 1'b1;
    assign idx_d      = tick ? idx_q + 3'd1 : idx_q;
    assign shadow_d   = (load_pending_q || frame_tick) ? bus.digits_in : shadow_q;

`ifdef DISPLAY_SCAN_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [BW-1:0] blink_cnt_q;
    logic          phase_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end
    assign phase_on = phase_q;
`else
    // Always true for any legal BLINK_FRAMES: without blinking the phase stays on.
    assign phase_on = (BLINK_FRAMES > 0);
`endif

    // all_zero[i]: nibbles 7 down to i are all literally 0x0.
    always_comb begin
        all_zero[7] = (shadow_q[31:28] == 4'h0);
        for (int i = 6; i >= 0; i--)
            all_zero[i] = all_zero[i+1] && (shadow_q[4*i +: 4] == 4'h0);
    end

    // Later assignments take priority, so the rules are applied lowest-priority first.
    always_comb begin
        logic [3:0] nib;
        nib   = shadow_q[{idx_d, 2'b00} +: 4];
        num_d = (nib >= 4'hC) ? 4'hB : nib;
        if (bus.lz_en && (idx_d != 3'd0) && all_zero[idx_d])
            num_d = 4'hB;
        if (!phase_on && bus.blink_mask[idx_d])
            num_d = 4'hB;
        if (!bus.digit_en[idx_d])
            num_d = 4'hB;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q          <= '0;
            idx_q          <= 3'd0;
            an_q           <= 8'h01;
            num_q          <= 4'hB;
            shadow_q       <= 32'hBBBB_BBBB;
            load_pending_q <= 1'b1;
        end else begin
            div_q          <= div_d;
            idx_q          <= idx_d;
            an_q           <= 8'h01 << idx_d;
            num_q          <= num_d;
            shadow_q       <= shadow_d;
            load_pending_q <= 1'b0;
        end
    end

    assign bus.num      = num_q;
    assign bus.an_sel   = an_q;
    assign bus.scan_idx = idx_q;
endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan: driver pushes expected outputs from an arithmetic model, monitor compares.
module tb_display_scan;
    localparam int S  = 4;
    localparam int BF = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    display_scan_if bus();

    display_scan #(.SCAN_DIV(S), .BLINK_FRAMES(BF)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] an;
        logic [3:0] num;
        logic [2:0] idx;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_edge = 0;
    logic [31:0] m_sh = 32'hBBBB_BBBB;

    logic [31:0] d_dig = 32'h0;
    logic [7:0]  d_en  = 8'hFF;
    logic        d_lz  = 1'b0;
    logic [7:0]  d_bm  = 8'h00;

    // Blink phase seen by edge n: frame ticks happen at edges 8S, 16S, ... and only earlier ones count.
    function automatic bit phase_on(int n);
`ifdef DISPLAY_SCAN_BLINK_EN
        return ((((n - 1) / (8 * S)) / BF) % 2) == 0;
`else
        return n >= 0;
`endif
    endfunction

    function automatic logic [3:0] ref_code(int i, logic [31:0] sh, logic [7:0] en,
                                            logic lz, logic [7:0] bm, bit on);
        logic [3:0] nib;
        nib = sh[4*i +: 4];
        if (!en[i])                                return 4'hB;
        if (!on && bm[i])                          return 4'hB;
        if (lz && i >= 1 && (sh >> (4 * i)) == 0)  return 4'hB;
        if (nib >= 4'hC)                           return 4'hB;
        return nib;
    endfunction

    // One clock: apply inputs at the falling edge and predict the state after the next rising edge.
    task automatic cyc(input bit rst);
        exp_t e;
        int   idx;
        @(negedge clk);
        bus.digits_in  = d_dig;
        bus.digit_en   = d_en;
        bus.lz_en      = d_lz;
        bus.blink_mask = d_bm;
        rst_n          = !rst;
        if (rst) begin
            n_edge = 0;
            m_sh   = 32'hBBBB_BBBB;
            e      = '{an: 8'h01, num: 4'hB, idx: 3'd0};
        end else begin
            n_edge++;
            idx   = (n_edge / S) % 8;
            e.idx = 3'(idx);
            e.an  = 8'h01 << idx;
            e.num = ref_code(idx, m_sh, d_en, d_lz, d_bm, phase_on(n_edge));
            if (n_edge == 1 || n_edge % (8 * S) == 0) m_sh = d_dig;
        end
        sb.push_back(e);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("an_sel",   int'(bus.an_sel),   int'(e.an));
                chk("num",      int'(bus.num),      int'(e.num));
                chk("scan_idx", int'(bus.scan_idx), int'(e.idx));
            end
        end
    end

    function automatic logic [31:0] rand_digits();
        logic [31:0] v;
        int          lead;
        v    = $urandom;
        lead = $urandom_range(0, 8);
        for (int i = 0; i < 8; i++) begin
            if (i >= 8 - lead) v[4*i +: 4] = 4'h0;
            else if ($urandom_range(0, 3) == 0) v[4*i +: 4] = 4'h0;
        end
        return v;
    endfunction

    initial begin : driver
        bus.digits_in  = 32'h0;
        bus.digit_en   = 8'hFF;
        bus.lz_en      = 1'b0;
        bus.blink_mask = 8'h00;
        do_reset(3);

        d_dig = 32'h1234_5678;
        run(16 * S);

        d_lz = 1'b1; d_dig = 32'h0000_0105; run(16 * S);
        d_dig = 32'h0000_0000; run(16 * S);
        d_dig = 32'h0000_0A03; run(16 * S);
        d_lz = 1'b0; d_dig = 32'hFEDC_0000; run(16 * S);

        // Mid-frame change must not tear the frame being shown.
        d_dig = 32'h1111_1111; run(16 * S - (n_edge % (8 * S)) + 3 * S + 1);
        d_dig = 32'h2222_2222; run(16 * S);

        d_en = 8'hF0; d_dig = 32'h8888_8888; run(16 * S);

        d_en = 8'hFF; d_dig = 32'h0000_0007; d_bm = 8'h01;
        do_reset(2);
        run(48 * S);

        // Reset while digit 5 is lit.
        d_dig = 32'h1234_5678; d_bm = 8'h00;
        run(5 * S + 2);
        do_reset(2);
        run(16 * S);

        for (int seg = 0; seg < 40; seg++) begin
            d_dig = rand_digits();
            d_en  = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            d_lz  = 1'($urandom);
            d_bm  = 8'($urandom);
            if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 2));
            for (int k = 0; k < int'($urandom_range(S, 24 * S)); k++) begin
                if ($urandom_range(0, 15) == 0) d_lz = 1'($urandom);
                if ($urandom_range(0, 15) == 0) d_en[$urandom_range(0, 7)] ^= 1'b1;
                if ($urandom_range(0, 31) == 0) d_dig = rand_digits();
                cyc(1'b0);
            end
        end

        @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexed scan controller for the 8-digit seven-segment display. It latches a frame of eight 4-bit digit codes and applies digit-enable masking, leading-zero blanking and optional blinking. It then steps a one-hot digit select at a fixed refresh rate. Its `num` output drives the digit-to-segment decoder directly, so `num` and `an_sel` together drive the display.

## Interface
- `SCAN_DIV`, 100000: clk cycles each digit stays lit; legal range ≥ 2.
- `BLINK_FRAMES`, 125: full 8-digit frames per blink half-period; legal range ≥ 1; used only with `DISPLAY_SCAN_BLINK_EN`.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `digits_in`  in  32  eight digit codes; nibble i = `digits_in[4i+3:4i]`; i=0 is the rightmost digit. Codes 0x0–0x9 are digits, 0xA is minus, 0xB is blank.
- `digit_en`  in  8  bit i=0 forces digit i blank.
- `lz_en`  in  1  enables leading-zero blanking.
- `blink_mask`  in  8  bit i=1 makes digit i blink.
- `num`  out  4  code of the digit currently selected; feeds the decoder.
- `an_sel`  out  8  one-hot digit select, active-high; bit i lights digit i.
- `scan_idx`  out  3  index of the digit currently selected.

## Operation
- **Divider.** `div` counts 0..SCAN_DIV-1 and wraps. The wrap cycle is the "tick".
- **Scan index.** On each tick, `scan_idx` advances 0→1→…→7→0.
  - The tick where the index goes from 7 to 0 is the "frame tick".
- **Shadow register.** `shadow[31:0]` loads `digits_in` on every frame tick.
  - It also loads once on the first cycle after reset release, via a `load_pending` flag that reset sets and the first load clears.
  - Changes to `digits_in` mid-frame are never displayed until the next load, so frames do not tear.
- **Code normalisation.** Shadow codes 0xC–0xF are treated as 0xB.
- **Digit code selection.** The code for digit i is taken from the first rule below that applies:
  1. `digit_en[i]`=0 → 0xB.
  2. Blink off-phase and `blink_mask[i]`=1 → 0xB (only with the macro).
  3. `lz_en`=1, i≥1, and every shadow nibble from index 7 down to i is 0x0 → 0xB.
     - 0xA counts as non-zero.
     - Digit 0 is never zero-blanked.
  4. Otherwise → the normalised shadow nibble.
- **Registered outputs.** `num`, `an_sel` and `scan_idx` are registered and always mutually consistent: `an_sel` = 1<<`scan_idx`, and `num` = code(`scan_idx`).
- **Live controls.** `num` is recomputed every cycle, so changes on `digit_en`, `lz_en` and `blink_mask` appear one cycle later, even mid-digit.

## Timing
- **Reset values:** `div`=0, `scan_idx`=0, `an_sel`=8'h01, `num`=4'hB, `shadow`=32'hBBBB_BBBB, `load_pending`=1, blink phase = on, blink counter = 0.
- **First cycle after release:** `shadow` loads. `num` shows the code of digit 0 one cycle after that.
- **Digit stepping:**
  - Each digit occupies exactly SCAN_DIV cycles; a frame is 8·SCAN_DIV cycles.
  - `an_sel`, `scan_idx` and `num` change on the same edge as the tick.
  - No blank gap is inserted between digits.
- **Frame tick:**
  - The new `shadow` value is visible in `num` one cycle after the frame tick, so digit 0 shows the old frame's value for one cycle.
  - If `digits_in` changes on the frame-tick cycle itself, the value sampled at that edge is loaded.
- **Reset asserted mid-frame:** all state returns to reset values immediately; no partial frame completes.

## Configuration
- **`DISPLAY_SCAN_BLINK_EN` defined:**
  - A frame counter counts 0..BLINK_FRAMES-1 on frame ticks.
  - The blink phase toggles on wrap.
  - Phase is "on" for the first BLINK_FRAMES frames after reset.
- **Macro undefined:**
  - The blink counter and phase logic are absent.
  - The `blink_mask` port remains but is ignored; the phase is permanently "on".

## Test plan
All scenarios use SCAN_DIV=4, except where stated.
1. **Reset and mid-frame reset.**
   - Release reset → `an_sel`=01 and `num`=B in the release cycle, then `an_sel`=02 exactly 4 cycles later.
   - Assert `rst_n`=0 during digit 5 → `an_sel`=01, `scan_idx`=0, `num`=B immediately.
2. **Scan order.** `digits_in`=32'h1234_5678, `digit_en`=FF, `lz_en`=0 → over one frame, `num` is 8,7,6,5,4,3,2,1 for `scan_idx` 0..7; each lasts 4 cycles; `an_sel` = 1<<`scan_idx`.
3. **Leading-zero blanking.**
   - `lz_en`=1, `digits_in`=32'h0000_0105 → indices 7..3 show B; idx2=1, idx1=0, idx0=5.
   - `digits_in`=0 → only idx0 shows 0.
   - 32'h0000_0A03 → idx2=A (minus), idx1=0.
4. **Frame-atomic latching.** Change `digits_in` from 32'h1111_1111 to 32'h2222_2222 while `scan_idx`=3 → digits 3..7 still show 1; from the next frame (after the one-cycle lag on digit 0) all digits show 2.
5. **Digit enable.** `digit_en`=F0, `digits_in`=32'h8888_8888 → `num`=B for idx 0..3 and 8 for idx 4..7; `an_sel` still steps through all 8 positions.
6. **Blink.** Macro defined, BLINK_FRAMES=2, `blink_mask`=01, `digits_in`=32'h0000_0007 → idx0 shows 7 in frames 0–1, B in frames 2–3, 7 in frames 4–5. With the macro undefined → 7 in every frame.
